// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared definitions for the instruction-fetch front end.
//   - PC_SEL_STATE_*  : next-PC select encoding shared with pcgen
//   - INITIAL_PC_VALUE: fetch PC loaded on reset
//   - ifu_state_e     : fetch FSM state encoding (IFU_ST_*)
package ifetch_unit_pkg;

    localparam int unsigned PC_SEL_W = 2;

    localparam logic [PC_SEL_W-1:0] PC_SEL_STATE_ADD    = 2'd0;
    localparam logic [PC_SEL_W-1:0] PC_SEL_STATE_BRANCH = 2'd1;
    localparam logic [PC_SEL_W-1:0] PC_SEL_STATE_JUMP   = 2'd2;
    localparam logic [PC_SEL_W-1:0] PC_SEL_STATE_REG    = 2'd3;

    localparam logic [31:0] INITIAL_PC_VALUE = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFU_ST_REQ   = 2'd0,
        IFU_ST_WAIT  = 2'd1,
        IFU_ST_HOLD  = 2'd2,
        IFU_ST_FAULT = 2'd3
    } ifu_state_e;

    // Any select other than sequential add is a control-flow redirect.
    function automatic logic is_redirect(input logic [PC_SEL_W-1:0] sel);
        return sel != PC_SEL_STATE_ADD;
    endfunction

endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC owner and single-outstanding instruction fetcher.
// Ports:
//   i_clk, i_rstn                   clock, async active-low reset
//   o_pc / i_npc / i_pc_sel         PC loop with the external pcgen
//   o_imem_req_valid/ready, o_imem_addr, i_imem_rsp_valid/data
//                                   instruction memory request/response
//   o_inst_valid/i_inst_ready, o_inst, o_inst_pc
//                                   instruction handoff to decode
//   o_misalign                      misaligned redirect fault
// Build option: IFETCH_MISALIGN_CHECK_EN enables the FAULT state for
// redirects to targets with nonzero low two bits.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    output logic [AWIDTH-1:0] o_pc,
    input  logic [AWIDTH-1:0] i_npc,
    input  logic [1:0]        i_pc_sel,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [AWIDTH-1:0] o_imem_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [DWIDTH-1:0] i_imem_rsp_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [DWIDTH-1:0] o_inst,
    output logic [AWIDTH-1:0] o_inst_pc,
    output logic              o_misalign
);

    ifu_state_e        state_q;
    logic [AWIDTH-1:0] pc_q;
    logic              kill_q;
    logic              req_valid_q;
    logic              inst_valid_q;
    logic [DWIDTH-1:0] inst_q;
    logic [AWIDTH-1:0] inst_pc_q;
    logic              misalign_q;

    logic redirect;
    logic advance;
    logic accept;
    logic rsp_pending;
    logic npc_mis;
    logic pc_mis;

    assign redirect = is_redirect(i_pc_sel);
    assign advance  = inst_valid_q & i_inst_ready & ~redirect;
    assign accept   = req_valid_q & i_imem_req_ready;

    // A response is still owed after this cycle; a response arriving in the
    // same cycle as the redirect has already been consumed and is not owed.
    assign rsp_pending = ((state_q == IFU_ST_WAIT) && !i_imem_rsp_valid) ||
                         ((state_q == IFU_ST_REQ) && accept);

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign npc_mis = (i_npc[1:0] != 2'b00);
    assign pc_mis  = (pc_q[1:0] != 2'b00);
`else
    assign npc_mis = 1'b0;
    assign pc_mis  = 1'b0;
`endif

    // Fetch FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= IFU_ST_REQ;
            pc_q         <= AWIDTH'(INITIAL_PC_VALUE);
            kill_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            misalign_q   <= 1'b0;
        end else if (redirect) begin
            pc_q         <= i_npc;
            inst_valid_q <= 1'b0;
            if (rsp_pending) begin
                // Drain the in-flight response before fetching the target.
                state_q     <= IFU_ST_WAIT;
                kill_q      <= 1'b1;
                req_valid_q <= 1'b0;
            end else begin
                kill_q <= 1'b0;
                if (npc_mis) begin
                    state_q     <= IFU_ST_FAULT;
                    req_valid_q <= 1'b0;
                    misalign_q  <= 1'b1;
                end else begin
                    state_q     <= IFU_ST_REQ;
                    req_valid_q <= 1'b1;
                    misalign_q  <= 1'b0;
                end
            end
        end else begin
            unique case (state_q)
                IFU_ST_REQ: begin
                    // Request goes up the first cycle after reset release.
                    if (!req_valid_q) begin
                        req_valid_q <= 1'b1;
                    end else if (accept) begin
                        req_valid_q <= 1'b0;
                        state_q     <= IFU_ST_WAIT;
                    end
                end
                IFU_ST_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_q <= 1'b0;
                            if (pc_mis) begin
                                state_q    <= IFU_ST_FAULT;
                                misalign_q <= 1'b1;
                            end else begin
                                state_q     <= IFU_ST_REQ;
                                req_valid_q <= 1'b1;
                            end
                        end else begin
                            inst_q       <= i_imem_rsp_data;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            state_q      <= IFU_ST_HOLD;
                        end
                    end
                end
                IFU_ST_HOLD: begin
                    if (advance) begin
                        pc_q         <= i_npc;
                        inst_valid_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                        state_q      <= IFU_ST_REQ;
                    end
                end
                IFU_ST_FAULT: begin
                    // Parked until an aligned redirect.
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc             = pc_q;
    assign o_imem_addr      = pc_q;
    assign o_imem_req_valid = req_valid_q;
    assign o_inst_valid     = inst_valid_q;
    assign o_inst           = inst_q;
    assign o_inst_pc        = inst_pc_q;
    assign o_misalign       = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed, table-driven bench for ifetch_unit with a small
// pcgen stand-in (npc = pc + 4 on ADD, else the driven target).
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic [1:0]    pc_sel;
    logic [AW-1:0] target;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          misalign;

    int tests;
    int fails;

    ifetch_unit #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .i_clk            (clk),
        .i_rstn           (rst_n),
        .o_pc             (pc),
        .i_npc            (npc),
        .i_pc_sel         (pc_sel),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_misalign       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pcgen stand-in
    always_comb npc = (pc_sel == PC_SEL_STATE_ADD) ? pc + 32'd4 : target;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [1:0] sel, input logic [31:0] tgt,
                                 input logic rr, input logic rv, input logic [31:0] rd,
                                 input logic ir, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_iv, input logic [31:0] e_inst,
                                 input logic [31:0] e_ipc);
        vec_t v;
        v.sel = sel; v.tgt = tgt; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] tgt, input logic rr,
                         input logic rv, input logic [31:0] rd, input logic ir);
        pc_sel = sel; target = tgt; req_ready = rr; rsp_valid = rv; rsp_data = rd; inst_ready = ir;
    endtask

    localparam logic [31:0] I0 = 32'h1111_0000;
    localparam logic [31:0] I1 = 32'h1111_0001;
    localparam logic [31:0] I2 = 32'h1111_0002;
    localparam logic [31:0] I3 = 32'h1111_0003;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(PC_SEL_STATE_ADD, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        // sel, tgt, rr, rv, rd, ir | e_req, e_addr, e_iv, e_inst, e_ipc
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 1, 32'h0,   0, 0,  0));      // req raised
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 0, 32'h0,   0, 0,  0));      // accept
        vecs.push_back(mkv(2'd0, 0, 1, 1, I0,  1, 0, 32'h0,   1, I0, 0));      // rsp -> HOLD
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 1, 32'h4,   0, I0, 0));      // advance
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 0, 32'h4,   0, I0, 0));
        vecs.push_back(mkv(2'd0, 0, 1, 1, I1,  1, 0, 32'h4,   1, I1, 32'h4));
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 1, 32'h8,   0, I1, 32'h4));
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 0, 32'h8,   0, I1, 32'h4));
        vecs.push_back(mkv(2'd0, 0, 1, 1, I2,  1, 0, 32'h8,   1, I2, 32'h8));
        for (int i = 0; i < 5; i++)                                             // decode stall
            vecs.push_back(mkv(2'd0, 0, 1, 0, 0, 0, 0, 32'h8, 1, I2, 32'h8));
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 1, 32'hC,   0, I2, 32'h8));
        for (int i = 0; i < 4; i++)                                             // memory stall
            vecs.push_back(mkv(2'd0, 0, 0, 0, 0, 1, 1, 32'hC, 0, I2, 32'h8));
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 0, 32'hC,   0, I2, 32'h8));  // accepted on 5th
        vecs.push_back(mkv(2'd2, 32'h100, 0, 0, 0, 1, 0, 32'h100, 0, I2, 32'h8)); // redirect in WAIT
        vecs.push_back(mkv(2'd0, 0, 0, 1, BAD, 1, 1, 32'h100, 0, I2, 32'h8));  // dropped
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 0, 32'h100, 0, I2, 32'h8));
        vecs.push_back(mkv(2'd0, 0, 1, 1, I3,  1, 0, 32'h100, 1, I3, 32'h100));
        vecs.push_back(mkv(2'd1, 32'h40, 0, 0, 0, 1, 1, 32'h40, 0, I3, 32'h100)); // redirect beats advance
        vecs.push_back(mkv(2'd2, 32'h80, 1, 0, 0, 1, 0, 32'h80, 0, I3, 32'h100)); // redirect + accept
        vecs.push_back(mkv(2'd3, 32'h90, 0, 0, 0, 1, 0, 32'h90, 0, I3, 32'h100)); // redirect in kill-WAIT
        vecs.push_back(mkv(2'd0, 0, 0, 1, BAD, 1, 1, 32'h90, 0, I3, 32'h100)); // drained
        vecs.push_back(mkv(2'd0, 0, 0, 0, 0,   1, 1, 32'h90,  0, I3, 32'h100));
        vecs.push_back(mkv(2'd0, 0, 1, 0, 0,   1, 0, 32'h90,  0, I3, 32'h100));
        vecs.push_back(mkv(2'd2, 32'h300, 0, 1, BAD, 1, 1, 32'h300, 0, I3, 32'h100)); // redirect + rsp same cycle
        vecs.push_back(mkv(2'd0, 0, 0, 0, 0,   1, 1, 32'h300, 0, I3, 32'h100));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(req_valid), 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].sel, vecs[k].tgt, vecs[k].rr, vecs[k].rv, vecs[k].rd, vecs[k].ir);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_req_valid", k), 32'(req_valid), 32'(vecs[k].e_req));
            check($sformatf("v%0d_addr", k), addr, vecs[k].e_addr);
            check($sformatf("v%0d_pc", k), pc, vecs[k].e_addr);
            check($sformatf("v%0d_inst_valid", k), 32'(inst_valid), 32'(vecs[k].e_iv));
            check($sformatf("v%0d_inst", k), inst, vecs[k].e_inst);
            check($sformatf("v%0d_inst_pc", k), inst_pc, vecs[k].e_ipc);
            check($sformatf("v%0d_misalign", k), 32'(misalign), 32'h0);
        end

        // Async reset while waiting on a response
        drive(PC_SEL_STATE_ADD, 0, 1'b1, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        check("ar_in_wait", 32'(req_valid), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req_valid", 32'(req_valid), 32'h0);
        check("ar_inst_valid", 32'(inst_valid), 32'h0);
        check("ar_pc", pc, 32'h0);
        check("ar_inst", inst, 32'h0);
        check("ar_inst_pc", inst_pc, 32'h0);
        rsp_valid = 1'b1;
        rsp_data  = BAD;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_req_raised", 32'(req_valid), 32'h1);
        check("ar_stray_iv", 32'(inst_valid), 32'h0);
        drive(PC_SEL_STATE_ADD, 0, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        check("ar_req_held", 32'(req_valid), 32'h1);
        check("ar_addr", addr, 32'h0);
        check("ar_stray_iv2", 32'(inst_valid), 32'h0);

        // Misaligned redirect
        drive(PC_SEL_STATE_JUMP, 32'h102, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("mis_flag", 32'(misalign), 32'h1);
        check("mis_no_req", 32'(req_valid), 32'h0);
        drive(PC_SEL_STATE_ADD, 0, 1'b1, 1'b1, BAD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mis_hold_flag", 32'(misalign), 32'h1);
            check("mis_hold_req", 32'(req_valid), 32'h0);
            check("mis_hold_iv", 32'(inst_valid), 32'h0);
        end
        drive(PC_SEL_STATE_JUMP, 32'h106, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        check("mis_again_flag", 32'(misalign), 32'h1);
        check("mis_again_req", 32'(req_valid), 32'h0);
        drive(PC_SEL_STATE_JUMP, 32'h200, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        check("mis_exit_flag", 32'(misalign), 32'h0);
        check("mis_exit_req", 32'(req_valid), 32'h1);
        check("mis_exit_addr", addr, 32'h200);
`else
        check("mis_off_flag", 32'(misalign), 32'h0);
        check("mis_off_req", 32'(req_valid), 32'h1);
        check("mis_off_addr", addr, 32'h102);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the bench itself stalls
    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, got t=%0t expected < 20000", $time);
        $fatal(1);
    end

endmodule
